cordic_phase_gen: RTL and testbench
===================================

# cordic_phase_gen

Numerically-controlled phase source that feeds the `cordic` rotation core. It accumulates a 32-bit phase with a programmable frequency tuning word, and folds each sample into the core's convergence range [-π/2, π/2]. It then scales the folded sample to the core's signed Q2.13 radian angle format and presents it through a valid/ready handshake. A per-sample `neg_xy` flag tells the downstream stage to negate both X and Y, which undoes the ±π fold.

## Interface
- `PHASE_W`, 32: accumulator width; full scale 2^PHASE_W = 2π.
- `ANGLE_W`, 16: output angle width, signed Q2.13 radians.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ftw_in`  in  PHASE_W: frequency tuning word.
- `ftw_load`  in  1: captures `ftw_in` into the FTW register.
- `phase_clr`  in  1: clears the accumulator to 0 and flushes the pipeline.
- `run`  in  1: enables sample issue.
- `out_valid`  out  1: `angle_out`/`neg_xy` hold a valid sample.
- `out_ready`  in  1: the downstream stage accepts the sample this cycle.
- `angle_out`  out  ANGLE_W: folded angle, Q2.13, range [-0x3244, +0x3244].
- `neg_xy`  out  1: the downstream stage must negate both X and Y results.

## Operation
- Reset: `ftw`=0, `phase_acc`=0, all pipeline valid bits 0, `out_valid`=0, `angle_out`=0, `neg_xy`=0.
- `adv` = `!out_valid || out_ready`. The whole pipeline moves only when `adv`=1; otherwise every register holds.
- Issue: when `run && adv && !phase_clr`:
  - stage 1 captures `phase_acc` with valid=1;
  - then `phase_acc` += `ftw`, mod 2^32, wrapping silently.
  - The first sample after clear or reset is phase 0.
- When `adv`=1 and no issue occurs, a bubble (valid=0) enters stage 1.
- Fold (stage 1 → 2):
  - q = phase[31:30].
  - If q is 01 or 10: r = phase − 0x8000_0000 and `neg`=1.
  - Otherwise: r = phase and `neg`=0.
  - r is interpreted as signed, within [-2^30, 2^30).
- Scale (stage 2 → output):
  - s = r >>> 14 (arithmetic shift, 17-bit signed).
  - p = s × 25736 (0x6488 = π in Q2.13), 33-bit signed.
  - `angle_out` = (p + 2^16) >>> 17, truncated to 16 bits. This is round-half-up; the result never exceeds ±12868.
- `ftw_load`: `ftw` ← `ftw_in` at the clock edge. An increment in the same cycle uses the old `ftw`.
- `phase_clr`: `phase_acc` ← 0 and all valid bits ← 0, including `out_valid`, regardless of `out_ready`. It has priority over issue and over stall. `ftw` is retained.
- `ftw_load` together with `phase_clr`: both take effect.
- `rst` mid-stream: same as reset. In-flight samples are discarded and `ftw` returns to 0.

## Timing
- Latency: a sample issued at edge N appears with `out_valid`=1 after edge N+2, provided there is no stall.
- Throughput: one sample per cycle while `run`=1 and `out_ready`=1.
- Handshake:
  - While `out_valid`=1 and `out_ready`=0, `angle_out` and `neg_xy` stay stable and `phase_acc` is frozen.
  - A sample transfers on any edge where `out_valid && out_ready`.
  - `out_valid` does not depend combinationally on `out_ready`.
- Deasserting `run` stops issue. Samples already in flight still drain.

## Structure
- Package `cordic_pkg` holds:
  - `ANGLE_W` = 16 and `ANGLE_FRAC` = 13;
  - `PI_Q2_13` = 16'h6488 and `HALF_PI_Q2_13` = 16'h3244;
  - `PHASE_W` = 32;
  - typedef `angle_t` (logic signed [15:0]).
- One sub-module, `cordic_phase_fold`: a purely combinational fold-and-scale, taking phase in and giving {angle, neg} out. The top level wraps it with the registers, accumulator and handshake logic.

## Test plan
- Reset:
  - Stimulus: hold `rst` for 3 cycles with arbitrary inputs.
  - Response: `out_valid`=0, `angle_out`=0, `neg_xy`=0. After release with `run`=1 and `ftw`=0, every sample is angle 0 with `neg`=0.
- Quadrants:
  - Stimulus: `ftw_load` 0x4000_0000, `phase_clr`, then `run`=1 with `out_ready`=1.
  - Response (angle/neg sequence): 0x0000/0, 0xCDBC/1, 0x0000/1, 0xCDBC/0, repeating. The first valid sample appears 2 cycles after the first issue.
- Fine step:
  - Stimulus: `ftw` 0x0400_0000.
  - Response: second sample angle = 804, and 16th sample (phase 0x3C00_0000) = 12064; both with `neg`=0. Phase 0x3FFF_FFFF gives 12868/0.
- Backpressure:
  - Stimulus: `out_ready`=0 for 5 cycles mid-stream.
  - Response: outputs are held constant during the stall. After the stall, the sequence continues with no gap, duplicate or skip versus the reference model.
- Clear/reload:
  - `phase_clr` pulse while stalled: `out_valid` drops the next cycle, and the next issued sample is phase 0.
  - `ftw_load` mid-stream: the new step applies from the following increment.
- Random:
  - Stimulus: 10k cycles of random `ftw`, `run`, `out_ready`, and rare `phase_clr`/`rst`.
  - Response: every accepted sample matches a golden model of accumulate, fold and round.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC phase source and rotation core.
package cordic_pkg;
  localparam int unsigned PHASE_W    = 32;
  localparam int unsigned ANGLE_W    = 16;
  localparam int unsigned ANGLE_FRAC = 13;

  localparam logic [15:0] PI_Q2_13      = 16'h6488;
  localparam logic [15:0] HALF_PI_Q2_13 = 16'h3244;

  typedef logic signed [15:0] angle_t;
endpackage

// File: rtl/cordic_phase_fold.sv
// Combinational fold of a full-circle phase into [-pi/2, pi/2] and scaling
// of the folded value to a Q2.13 radian angle with round-half-up.
module cordic_phase_fold
  import cordic_pkg::*;
(
  input  logic [PHASE_W-1:0] phase_in,
  output angle_t             angle_out,
  output logic               neg_out
);

  logic [31:0] r_s;
  logic [16:0] s_s;
  logic [32:0] p_s;
  logic [32:0] p_rnd_s;
  logic        unused_fold_s;

  // Quadrants 1 and 2 are shifted by pi, so the rotated result must be negated.
  always_comb begin
    case (phase_in[31:30])
      2'b01, 2'b10: begin
        r_s     = phase_in - 32'h8000_0000;
        neg_out = 1'b1;
      end
      default: begin
        r_s     = phase_in;
        neg_out = 1'b0;
      end
    endcase
    // r lies in [-2^30, 2^30), so bit 30 already carries the sign of r >>> 14.
    s_s       = r_s[30:14];
    p_s       = {{16{s_s[16]}}, s_s} * {17'd0, PI_Q2_13};
    p_rnd_s   = p_s + 33'd65536;
    angle_out = $signed(p_rnd_s[32:17]);
  end

  assign unused_fold_s = ^{r_s[31], r_s[13:0], p_rnd_s[16:0]};

endmodule

// File: rtl/cordic_phase_gen.sv
// Phase accumulator feeding a two-register fold/scale pipeline with a
// valid/ready output; every register advances only when the output can move.
module cordic_phase_gen #(
  parameter int PHASE_W = 32,
  parameter int ANGLE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] ftw_in,
  input  logic               ftw_load,
  input  logic               phase_clr,
  input  logic               run,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ANGLE_W-1:0] angle_out,
  output logic               neg_xy
);
  import cordic_pkg::*;

  logic [PHASE_W-1:0] ftw_q, ftw_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic               s1_vld_q, s1_vld_d;
  logic [PHASE_W-1:0] s1_phase_q, s1_phase_d;
  logic               s2_vld_q, s2_vld_d;
  angle_t             s2_angle_q, s2_angle_d;
  logic               s2_neg_q, s2_neg_d;
  logic               out_vld_q, out_vld_d;
  angle_t             out_angle_q, out_angle_d;
  logic               out_neg_q, out_neg_d;

  logic               adv_s;
  logic               issue_s;
  angle_t             fold_angle_s;
  logic               fold_neg_s;

  cordic_phase_fold u_fold (
    .phase_in  (s1_phase_q),
    .angle_out (fold_angle_s),
    .neg_out   (fold_neg_s)
  );

  // Next-state: clear beats advance; a stalled output freezes everything but ftw.
  always_comb begin
    adv_s       = !out_vld_q || out_ready;
    issue_s     = run && adv_s && !phase_clr;
    acc_d       = acc_q;
    s1_vld_d    = s1_vld_q;
    s1_phase_d  = s1_phase_q;
    s2_vld_d    = s2_vld_q;
    s2_angle_d  = s2_angle_q;
    s2_neg_d    = s2_neg_q;
    out_vld_d   = out_vld_q;
    out_angle_d = out_angle_q;
    out_neg_d   = out_neg_q;

    if (ftw_load) begin
      ftw_d = ftw_in;
    end else begin
      ftw_d = ftw_q;
    end

    if (phase_clr) begin
      acc_d     = '0;
      s1_vld_d  = 1'b0;
      s2_vld_d  = 1'b0;
      out_vld_d = 1'b0;
    end else if (adv_s) begin
      s1_vld_d    = issue_s;
      s1_phase_d  = acc_q;
      s2_vld_d    = s1_vld_q;
      s2_angle_d  = fold_angle_s;
      s2_neg_d    = fold_neg_s;
      out_vld_d   = s2_vld_q;
      out_angle_d = s2_angle_q;
      out_neg_d   = s2_neg_q;
      if (issue_s) begin
        acc_d = acc_q + ftw_q;
      end else begin
        acc_d = acc_q;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ftw_q       <= '0;
      acc_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_phase_q  <= '0;
      s2_vld_q    <= 1'b0;
      s2_angle_q  <= 16'sd0;
      s2_neg_q    <= 1'b0;
      out_vld_q   <= 1'b0;
      out_angle_q <= 16'sd0;
      out_neg_q   <= 1'b0;
    end else begin
      ftw_q       <= ftw_d;
      acc_q       <= acc_d;
      s1_vld_q    <= s1_vld_d;
      s1_phase_q  <= s1_phase_d;
      s2_vld_q    <= s2_vld_d;
      s2_angle_q  <= s2_angle_d;
      s2_neg_q    <= s2_neg_d;
      out_vld_q   <= out_vld_d;
      out_angle_q <= out_angle_d;
      out_neg_q   <= out_neg_d;
    end
  end

  assign out_valid = out_vld_q;
  assign angle_out = out_angle_q;
  assign neg_xy    = out_neg_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Self-checking bench: directed quadrant/step/stall/clear cases plus a long
// randomized run, all compared against a sample-level reference model.
module tb_cordic_phase_gen;

  logic        clk = 1'b0;
  logic        rst, ftw_load, phase_clr, run, out_ready;
  logic [31:0] ftw_in;
  logic        out_valid, neg_xy;
  logic [15:0] angle_out;

  int n_total = 0;
  int n_bad   = 0;

  // Reference: architectural phase/ftw plus the three sample slots ahead of the output.
  logic [31:0] m_ftw, m_acc;
  logic        m_v  [3];
  logic [31:0] m_ph [3];
  logic [16:0] got_q [$];

  always #5 clk = ~clk;

  cordic_phase_gen dut (
    .clk       (clk),
    .rst       (rst),
    .ftw_in    (ftw_in),
    .ftw_load  (ftw_load),
    .phase_clr (phase_clr),
    .run       (run),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .angle_out (angle_out),
    .neg_xy    (neg_xy)
  );

  function automatic logic [16:0] ref_fold(input logic [31:0] ph);
    longint r, s, p, a;
    logic   n;
    n = (ph[31:30] == 2'b01) || (ph[31:30] == 2'b10);
    r = longint'(ph);
    if (n) r = r - 64'sd2147483648;
    if (r >= 64'sd2147483648) r = r - 64'sd4294967296;
    s = r >>> 14;
    p = s * 64'sd25736;
    a = (p + 64'sd65536) >>> 17;
    return {n, a[15:0]};
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic adv;
    logic [31:0] old_ftw;
    if (rst) begin
      m_ftw = 32'd0;
      m_acc = 32'd0;
      for (int i = 0; i < 3; i++) m_v[i] = 1'b0;
    end else begin
      old_ftw = m_ftw;
      if (ftw_load) m_ftw = ftw_in;
      adv = !m_v[2] || out_ready;
      if (phase_clr) begin
        m_acc = 32'd0;
        for (int i = 0; i < 3; i++) m_v[i] = 1'b0;
      end else if (adv) begin
        m_v[2] = m_v[1]; m_ph[2] = m_ph[1];
        m_v[1] = m_v[0]; m_ph[1] = m_ph[0];
        m_v[0] = run;    m_ph[0] = m_acc;
        if (run) m_acc = m_acc + old_ftw;
      end
    end
  endtask

  task automatic check_outputs();
    logic [16:0] e;
    cmp("out_valid", {31'd0, out_valid}, {31'd0, m_v[2]});
    if (m_v[2]) begin
      e = ref_fold(m_ph[2]);
      cmp("angle", {16'd0, angle_out}, {16'd0, e[15:0]});
      cmp("neg_xy", {31'd0, neg_xy}, {31'd0, e[16]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    if (out_valid) got_q.push_back({neg_xy, angle_out});
  endtask

  task automatic restart(input logic [31:0] step);
    ftw_in = step; ftw_load = 1'b1; phase_clr = 1'b1; run = 1'b0; out_ready = 1'b1;
    tick();
    ftw_load = 1'b0; phase_clr = 1'b0; run = 1'b1;
    got_q.delete();
  endtask

  initial begin
    logic [16:0] held;
    logic [16:0] quad_exp [4];
    quad_exp[0] = {1'b0, 16'h0000};
    quad_exp[1] = {1'b1, 16'hCDBC};
    quad_exp[2] = {1'b1, 16'h0000};
    quad_exp[3] = {1'b0, 16'hCDBC};

    // Hand-computed anchors for the reference fold itself.
    cmp("pin_q1", {15'd0, ref_fold(32'h4000_0000)}, {15'd0, 1'b1, 16'hCDBC});
    cmp("pin_fine", {15'd0, ref_fold(32'h3C00_0000)}, {15'd0, 1'b0, 16'd12064});
    cmp("pin_max", {15'd0, ref_fold(32'h3FFF_FFFF)}, {15'd0, 1'b0, 16'd12868});

    rst = 1'b1; ftw_in = $urandom; ftw_load = 1'b1; phase_clr = 1'b0; run = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("rst_valid", {31'd0, out_valid}, 32'd0);
      cmp("rst_angle", {16'd0, angle_out}, 32'd0);
      cmp("rst_neg", {31'd0, neg_xy}, 32'd0);
    end
    rst = 1'b0; ftw_load = 1'b0; run = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // Quadrant walk with latency check.
    restart(32'h4000_0000);
    tick(); cmp("lat_e1", {31'd0, out_valid}, 32'd0);
    tick(); cmp("lat_e2", {31'd0, out_valid}, 32'd0);
    tick(); cmp("lat_e3", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 7; i++) tick();
    cmp("quad_count", got_q.size(), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      cmp("quad_seq", {15'd0, got_q[i]}, {15'd0, quad_exp[i % 4]});

    // Fine step.
    restart(32'h0400_0000);
    for (int i = 0; i < 20; i++) tick();
    if (got_q.size() >= 16) begin
      cmp("fine_2nd", {15'd0, got_q[1]}, {15'd0, 1'b0, 16'd804});
      cmp("fine_16th", {15'd0, got_q[15]}, {15'd0, 1'b0, 16'd12064});
    end else cmp("fine_count", got_q.size(), 32'd16);

    restart(32'h3FFF_FFFF);
    for (int i = 0; i < 5; i++) tick();
    if (got_q.size() >= 2) cmp("max_angle", {15'd0, got_q[1]}, {15'd0, 1'b0, 16'd12868});
    else cmp("max_count", got_q.size(), 32'd2);

    // Backpressure: outputs must hold through a five-cycle stall.
    restart(32'h1234_5679);
    for (int i = 0; i < 6; i++) tick();
    held = {neg_xy, angle_out};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cmp("stall_valid", {31'd0, out_valid}, 32'd1);
      cmp("stall_hold", {15'd0, neg_xy, angle_out}, {15'd0, held});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // Clear while stalled, then the first new sample must be phase 0.
    out_ready = 1'b0;
    tick(); tick();
    phase_clr = 1'b1;
    tick();
    cmp("clr_drop", {31'd0, out_valid}, 32'd0);
    phase_clr = 1'b0; out_ready = 1'b1; got_q.delete();
    for (int i = 0; i < 4; i++) tick();
    if (got_q.size() >= 1) cmp("clr_first", {15'd0, got_q[0]}, 32'd0);
    else cmp("clr_count", got_q.size(), 32'd1);

    // Reload mid-stream.
    ftw_in = 32'h0100_0000; ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // Randomized run.
    for (int i = 0; i < 10000; i++) begin
      rst       = ($urandom % 600) == 0;
      phase_clr = ($urandom % 50) == 0;
      ftw_load  = ($urandom % 25) == 0;
      case ($urandom % 4)
        0: ftw_in = $urandom;
        1: ftw_in = $urandom % 32'h0010_0000;
        2: ftw_in = 32'h4000_0000;
        default: ftw_in = 32'hFFFF_FFFF - ($urandom % 32'h0100_0000);
      endcase
      run       = ($urandom % 8) != 0;
      out_ready = ($urandom % 4) != 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
